// File: rtl/temp_sensor_if_if.sv
// 3-wire serial sensor bus: controller drives cs_n/sclk, the sensor drives sdata.
interface temp_sensor_if_if;
    logic cs_n;
    logic sclk;
    logic sdata;

    modport master (output cs_n, output sclk, input sdata);
    modport slave  (input cs_n, input sclk, output sdata);
endinterface

// File: rtl/temp_sensor_if.sv
// Polls a serial temperature sensor, rejects malformed frames, and averages
// 2^AVG_LOG2 good readings into a held 5-bit temperature value.
module temp_sensor_if #(
    parameter int             CLK_DIV    = 4,
    parameter int             SAMPLE_GAP = 16,
    parameter int             AVG_LOG2   = 2,
    parameter logic [4:0]     RESET_TEMP = 5'd20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    temp_sensor_if_if.master        sbus,
    output logic [4:0]              temperature,
    output logic                    temp_valid,
    output logic                    sample_err
);
    localparam int         CMAX = (CLK_DIV > SAMPLE_GAP) ? CLK_DIV : SAMPLE_GAP;
    localparam int         CW   = $clog2(CMAX + 1);
    localparam logic [3:0] NAVG = 4'(1 << AVG_LOG2);

    typedef enum logic [2:0] {IDLE, SELECT, SHIFT, CHECK, GAP} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [3:0]     half_q;
    logic [7:0]     shreg_q;
    logic [7:0]     acc_q;
    logic [3:0]     good_q;
    logic           cs_n_q, sclk_q;
    logic [4:0]     temp_q;
    logic           tv_q, se_q;

    logic           frame_ok;
    logic [7:0]     acc_d;
    logic [3:0]     good_d;

    // Header must be 2'b10 and bits[5:0] (temperature plus parity) must hold an even count of ones.
    assign frame_ok = (shreg_q[7:6] == 2'b10) && !(^shreg_q[5:0]);
    assign acc_d    = acc_q + 8'(shreg_q[5:1]);
    assign good_d   = good_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            shreg_q <= '0;
            acc_q   <= '0;
            good_q  <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            temp_q  <= RESET_TEMP;
            tv_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            tv_q <= 1'b0;
            se_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= SELECT;
                        cs_n_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                SELECT: begin
                    if (cnt_q == CW'(CLK_DIV - 1)) begin
                        cnt_q   <= '0;
                        half_q  <= '0;
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt_q == CW'(CLK_DIV - 1)) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        if (!sclk_q)
                            shreg_q <= {shreg_q[6:0], sbus.sdata};
                        // Last shift happened a half-period earlier, so shreg_q is complete here.
                        if (half_q == 4'd15) begin
                            state_q <= CHECK;
                            cs_n_q  <= 1'b1;
                            se_q    <= !frame_ok;
                        end else begin
                            half_q <= half_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    state_q <= GAP;
                    cnt_q   <= '0;
                    if (frame_ok) begin
                        if (good_d == NAVG) begin
                            temp_q <= 5'(acc_d >> AVG_LOG2);
                            tv_q   <= 1'b1;
                            acc_q  <= '0;
                            good_q <= '0;
                        end else begin
                            acc_q  <= acc_d;
                            good_q <= good_d;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q == CW'(SAMPLE_GAP - 1)) begin
                        cnt_q <= '0;
                        if (enable) begin
                            state_q <= SELECT;
                            cs_n_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sbus.cs_n   = cs_n_q;
    assign sbus.sclk   = sclk_q;
    assign temperature = temp_q;
    assign temp_valid  = tv_q;
    assign sample_err  = se_q;
endmodule
